// File: rtl/irq_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// irq_cfg_sequencer
//
// Owns the irq_router configuration bus. MCU routing commands arrive on a
// valid/ready port and are turned into single-cycle cfg_wr_en_o writes, each
// followed by WR_GAP idle cycles. Supported commands: write one entry
// (op 00), clear all entries (op 01), load the default map (op 10).
// op 11 is reserved and rejected.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   cmd_valid_i         command present
//   cmd_ready_o         sequencer can accept a command
//   cmd_op_i[1:0]       00 write, 01 clear all, 10 load default, 11 reserved
//   cmd_addr_i          entry address (op 00 only)
//   cmd_data_i[7:0]     entry value {en, 000, idx[3:0]} (op 00 only)
//   cfg_wr_en_o         router write strobe
//   cfg_rd_en_o         always 0
//   cfg_addr_o          router entry address (0 when not writing)
//   cfg_wdata_o[31:0]   {24'h0, entry} (0 when not writing)
//   busy_o              command in progress
//   done_o              one-cycle pulse when a command completes
//   err_o               one-cycle pulse when a command is rejected
//   dbg_state_o[2:0]    current FSM state, for observation
//
// Handshake: a command is taken on a rising edge where cmd_valid_i and
// cmd_ready_o are both high. cmd_ready_o is high only while idle, so
// cmd_valid_i may be held high during a command; it is taken on the first
// idle cycle. The command fields are only sampled at the handshake.
//
// All outputs are registered: each output register is loaded from the
// decode of the next state, so outputs line up with the state register.
// -----------------------------------------------------------------------------
module irq_cfg_sequencer #(
    parameter int NUM_SLOTS       = 5,
    parameter int NUM_TILE_INT_CH = 2,
    parameter int NUM_CPU_INT     = 4,
    parameter int CFG_ADDR_WIDTH  = 8,
    parameter int WR_GAP          = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic [1:0]                cmd_op_i,
    input  logic [CFG_ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [7:0]                cmd_data_i,
    output logic                      cfg_wr_en_o,
    output logic                      cfg_rd_en_o,
    output logic [CFG_ADDR_WIDTH-1:0] cfg_addr_o,
    output logic [31:0]               cfg_wdata_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic [2:0]                dbg_state_o
);

    localparam int INT_ENTRIES = NUM_SLOTS * NUM_TILE_INT_CH;
    localparam int TOTAL       = INT_ENTRIES + NUM_SLOTS;
    localparam int GAP_W       = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;

    localparam logic [CFG_ADDR_WIDTH-1:0] TOTAL_A = CFG_ADDR_WIDTH'(TOTAL);
    localparam logic [CFG_ADDR_WIDTH-1:0] LAST_A  = CFG_ADDR_WIDTH'(TOTAL - 1);
    localparam logic [CFG_ADDR_WIDTH-1:0] INT_A   = CFG_ADDR_WIDTH'(INT_ENTRIES);
    localparam logic [GAP_W-1:0]          GAP_LAST = GAP_W'((WR_GAP > 0) ? WR_GAP - 1 : 0);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_CLEAR = 2'b01;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_GAP   = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_e;

    state_e                      state_q, state_d;
    logic [1:0]                  op_q, op_d;
    logic [7:0]                  data_q, data_d;
    logic [CFG_ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [GAP_W-1:0]            gap_q, gap_d;

    logic                        ready_q, ready_d;
    logic                        wr_en_q, wr_en_d;
    logic [CFG_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]                  wdata_q, wdata_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        err_q, err_d;

    logic                        accept;
    logic                        reject;
    logic                        last_entry;

    // Value written to the router for a given op and entry index.
    // Default map: INT entries get channel index folded onto the CPU INT
    // pins, NMI entries all go to NMI pin 0. Both are enabled (bit 7).
    function automatic logic [7:0] entry_value(input logic [1:0]                op,
                                               input logic [CFG_ADDR_WIDTH-1:0] ptr,
                                               input logic [7:0]                data);
        logic [7:0] val;
        val = 8'h00;
        if (op == OP_WRITE) begin
            val = data;
        end else if (op == OP_CLEAR) begin
            val = 8'h00;
        end else if (ptr < INT_A) begin
            val = 8'h80 | {4'h0, 4'((32'(ptr) % NUM_TILE_INT_CH) % NUM_CPU_INT)};
        end else begin
            val = 8'h80;
        end
        return val;
    endfunction

    assign accept = cmd_valid_i & ready_q;
    assign reject = (cmd_op_i == OP_RSVD) ||
                    ((cmd_op_i == OP_WRITE) &&
                     ((cmd_addr_i >= TOTAL_A) || (cmd_data_i[6:4] != 3'b000)));
    // A single write always finishes after its one write; bulk ops finish
    // after the last route entry.
    assign last_entry = (op_q == OP_WRITE) || (ptr_q == LAST_A);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        ptr_d   = ptr_q;
        gap_d   = gap_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d   = cmd_op_i;
                    data_d = cmd_data_i;
                    ptr_d  = (cmd_op_i == OP_WRITE) ? cmd_addr_i : '0;
                    state_d = reject ? S_ERR : S_WRITE;
                end
            end
            S_WRITE: begin
                gap_d = '0;
                if (WR_GAP > 0) begin
                    state_d = S_GAP;
                end else if (last_entry) begin
                    state_d = S_DONE;
                end else begin
                    ptr_d   = ptr_q + 1'b1;
                    state_d = S_WRITE;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (last_entry) begin
                        state_d = S_DONE;
                    end else begin
                        ptr_d   = ptr_q + 1'b1;
                        state_d = S_WRITE;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Output decode of the next state, registered below.
        ready_d = (state_d == S_IDLE);
        wr_en_d = (state_d == S_WRITE);
        addr_d  = wr_en_d ? ptr_d : '0;
        wdata_d = wr_en_d ? entry_value(op_d, ptr_d, data_d) : 8'h00;
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
        err_d   = (state_d == S_ERR);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            op_q    <= 2'b00;
            data_q  <= 8'h00;
            ptr_q   <= '0;
            gap_q   <= '0;
            ready_q <= 1'b0;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            ptr_q   <= ptr_d;
            gap_q   <= gap_d;
            ready_q <= ready_d;
            wr_en_q <= wr_en_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign cmd_ready_o = ready_q;
    assign cfg_wr_en_o = wr_en_q;
    assign cfg_rd_en_o = 1'b0;
    assign cfg_addr_o  = addr_q;
    assign cfg_wdata_o = {24'h0, wdata_q};
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_irq_cfg_sequencer.sv
module tb_irq_cfg_sequencer;

  localparam int AW    = 8;
  localparam int TOTAL = 15;
  localparam int NINT  = 10;
  localparam int CH    = 2;
  localparam int CPU   = 4;
  localparam int GAP_A = 2;
  localparam int GAP_B = 0;
  localparam int W     = 56;   // {cycle[15:0], addr[7:0], wdata[31:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- stimulus signals ----------------
  logic          cmd_valid = 1'b0;
  logic          use_b     = 1'b0;
  logic [1:0]    cmd_op    = 2'b00;
  logic [AW-1:0] cmd_addr  = '0;
  logic [7:0]    cmd_data  = 8'h00;

  logic          a_valid, b_valid;
  logic          a_ready, a_wr, a_rd, a_busy, a_done, a_err;
  logic          b_ready, b_wr, b_rd, b_busy, b_done, b_err;
  logic [AW-1:0] a_addr, b_addr;
  logic [31:0]   a_wdata, b_wdata;
  logic [2:0]    a_dbg, b_dbg;

  assign a_valid = cmd_valid & ~use_b;
  assign b_valid = cmd_valid & use_b;

  logic          m_ready, m_wr, m_rd, m_busy, m_done, m_err;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  assign m_ready = use_b ? b_ready : a_ready;
  assign m_wr    = use_b ? b_wr    : a_wr;
  assign m_rd    = use_b ? b_rd    : a_rd;
  assign m_busy  = use_b ? b_busy  : a_busy;
  assign m_done  = use_b ? b_done  : a_done;
  assign m_err   = use_b ? b_err   : a_err;
  assign m_addr  = use_b ? b_addr  : a_addr;
  assign m_wdata = use_b ? b_wdata : a_wdata;

  irq_cfg_sequencer #(.WR_GAP(GAP_A)) dut_a (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(a_valid), .cmd_ready_o(a_ready),
    .cmd_op_i(cmd_op), .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data),
    .cfg_wr_en_o(a_wr), .cfg_rd_en_o(a_rd), .cfg_addr_o(a_addr), .cfg_wdata_o(a_wdata),
    .busy_o(a_busy), .done_o(a_done), .err_o(a_err), .dbg_state_o(a_dbg)
  );

  irq_cfg_sequencer #(.WR_GAP(GAP_B)) dut_b (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(b_valid), .cmd_ready_o(b_ready),
    .cmd_op_i(cmd_op), .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data),
    .cfg_wr_en_o(b_wr), .cfg_rd_en_o(b_rd), .cfg_addr_o(b_addr), .cfg_wdata_o(b_wdata),
    .busy_o(b_busy), .done_o(b_done), .err_o(b_err), .dbg_state_o(b_dbg)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int fails  = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_wr[$];
  int done_obs[$];
  int err_obs[$];

  // Monitor: log every strobe and pulse; bus must be quiet between writes.
  always @(negedge clk) begin
    if (m_wr === 1'b1) begin
      obs_wr.push_back({16'(cyc), m_addr, m_wdata});
    end else begin
      checks++;
      if (m_addr !== '0 || m_wdata !== 32'h0 || m_wr !== 1'b0) begin
        fails++;
        $display("FAIL idle_bus @%0d: wr %b addr %h wdata %h, want all 0", cyc, m_wr, m_addr, m_wdata);
      end
    end
    checks++;
    if (m_rd !== 1'b0) begin
      fails++;
      $display("FAIL rd_en @%0d: got %b want 0", cyc, m_rd);
    end
    if (m_done === 1'b1) done_obs.push_back(cyc);
    if (m_err === 1'b1) err_obs.push_back(cyc);
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] model_entry(input int op, input int p, input logic [7:0] d);
    if (op == 0) return d;
    if (op == 1) return 8'h00;
    if (p < NINT) return 8'h80 | 8'((p % CH) % CPU);
    return 8'h80;
  endfunction

  // Expected writes go to exp_q; returns the cycle of the done/err pulse.
  task automatic build_exp(input int op, input int addr, input logic [7:0] d, input int t,
                           input int gap, output int t_evt, output bit is_err);
    int n;
    is_err = (op == 3) || (op == 0 && (addr >= TOTAL || d[6:4] != 3'b000));
    if (is_err) begin
      t_evt = t + 1;
    end else begin
      n = (op == 0) ? 1 : TOTAL;
      for (int k = 0; k < n; k++) begin
        int p;
        p = (op == 0) ? addr : k;
        exp_q.push_back({16'(t + 1 + k * (1 + gap)), 8'(p), 32'(model_entry(op, p, d))});
      end
      t_evt = t + 1 + n * (1 + gap);
    end
  endtask

  task automatic clear_logs();
    exp_q.delete();
    obs_wr.delete();
    done_obs.delete();
    err_obs.delete();
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge; returns at the falling edge after the handshake.
  task automatic send_cmd(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] d,
                          output int t_hs, output bit ok);
    cmd_op = op; cmd_addr = addr; cmd_data = d; cmd_valid = 1'b1;
    ok = 1'b0; t_hs = -1;
    for (int i = 0; i < 200; i++) begin
      if (m_ready === 1'b1) begin
        t_hs = cyc; ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Returns at the falling edge of the cycle after the n-th done/err pulse.
  task automatic wait_events(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_obs.size() + err_obs.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_ready, a_wr, a_busy, a_done, a_err, b_ready, b_busy} !== 7'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b want 0000000", {a_ready, a_wr, a_busy, a_done, a_err, b_ready, b_busy});
    end
    checks++;
    if (a_addr !== '0 || a_wdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_bus: addr %h wdata %h want 0", a_addr, a_wdata);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1 || a_busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: ready a %b b %b busy %b, want 1 1 0", a_ready, b_ready, a_busy);
    end
  endtask

  task automatic test_single_write();
    int t, t_evt; bit ok, ok2, is_err; logic [W-1:0] e, o;
    clear_logs();
    send_cmd(2'b00, 8'd3, 8'h82, t, ok);
    build_exp(0, 3, 8'h82, t, GAP_A, t_evt, is_err);
    checks++;
    if (a_busy !== 1'b1 || a_ready !== 1'b0) begin
      fails++;
      $display("FAIL single_busy: busy %b ready %b want 1 0", a_busy, a_ready);
    end
    wait_events(1, 50, ok2);
    checks++;
    if (!ok || !ok2) begin
      fails++;
      $display("FAIL single_timeout: handshake %0d done %0d want 1 1", ok, ok2);
    end
    checks++;
    if (obs_wr.size() != exp_q.size()) begin
      fails++;
      $display("FAIL single_count: got %0d writes want %0d", obs_wr.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_wr.size() > 0) begin
      e = exp_q.pop_front(); o = obs_wr.pop_front();
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL single_write: got %h want %h", o, e);
      end
    end
    checks++;
    if (done_obs.size() != 1 || done_obs[0] != t_evt || t_evt != t + 4 || err_obs.size() != 0) begin
      fails++;
      $display("FAIL single_done: got %0d dones (first %0d) want one at %0d", done_obs.size(),
               (done_obs.size() > 0) ? done_obs[0] : -1, t + 4);
    end
    checks++;
    if (a_ready !== 1'b1 || a_busy !== 1'b0) begin
      fails++;
      $display("FAIL single_ready: ready %b busy %b want 1 0", a_ready, a_busy);
    end
  endtask

  task automatic test_load_default();
    int t, t_evt; bit ok, ok2, is_err; logic [W-1:0] e, o;
    clear_logs();
    send_cmd(2'b10, 8'($urandom_range(0, 255)), 8'($urandom), t, ok);
    build_exp(2, 0, 8'h00, t, GAP_A, t_evt, is_err);
    wait_events(1, 100, ok2);
    checks++;
    if (!ok || !ok2) begin
      fails++;
      $display("FAIL load_timeout: handshake %0d done %0d want 1 1", ok, ok2);
    end
    checks++;
    if (obs_wr.size() != exp_q.size()) begin
      fails++;
      $display("FAIL load_count: got %0d writes want %0d", obs_wr.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_wr.size() > 0) begin
      e = exp_q.pop_front(); o = obs_wr.pop_front();
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL load_write: got %h want %h", o, e);
      end
    end
    checks++;
    if (done_obs.size() != 1 || done_obs[0] != t_evt || t_evt != t + 46) begin
      fails++;
      $display("FAIL load_done: got %0d dones (first %0d) want one at %0d", done_obs.size(),
               (done_obs.size() > 0) ? done_obs[0] : -1, t + 46);
    end
    checks++;
    if (a_ready !== 1'b1) begin
      fails++;
      $display("FAIL load_ready: got %b want 1", a_ready);
    end
  endtask

  task automatic test_clear_gap0();
    int t, t_evt; bit ok, ok2, is_err; logic [W-1:0] e, o;
    clear_logs();
    use_b = 1'b1;
    send_cmd(2'b01, 8'($urandom_range(0, 255)), 8'($urandom), t, ok);
    build_exp(1, 0, 8'h00, t, GAP_B, t_evt, is_err);
    wait_events(1, 60, ok2);
    checks++;
    if (!ok || !ok2) begin
      fails++;
      $display("FAIL clear_timeout: handshake %0d done %0d want 1 1", ok, ok2);
    end
    checks++;
    if (obs_wr.size() != exp_q.size()) begin
      fails++;
      $display("FAIL clear_count: got %0d writes want %0d", obs_wr.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_wr.size() > 0) begin
      e = exp_q.pop_front(); o = obs_wr.pop_front();
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL clear_write: got %h want %h", o, e);
      end
    end
    checks++;
    if (done_obs.size() != 1 || done_obs[0] != t_evt || t_evt != t + 16) begin
      fails++;
      $display("FAIL clear_done: got %0d dones (first %0d) want one at %0d", done_obs.size(),
               (done_obs.size() > 0) ? done_obs[0] : -1, t + 16);
    end
    checks++;
    if (b_ready !== 1'b1) begin
      fails++;
      $display("FAIL clear_ready: got %b want 1", b_ready);
    end
    use_b = 1'b0;
  endtask

  task automatic test_rejects();
    logic [1:0] ops[3]   = '{2'b00, 2'b00, 2'b11};
    logic [7:0] addrs[3] = '{8'd15, 8'd2, 8'd1};
    logic [7:0] datas[3] = '{8'h81, 8'h90, 8'h80};
    for (int i = 0; i < 3; i++) begin
      int t, t_evt; bit ok, ok2, is_err;
      clear_logs();
      send_cmd(ops[i], addrs[i], datas[i], t, ok);
      build_exp(int'(ops[i]), int'(addrs[i]), datas[i], t, GAP_A, t_evt, is_err);
      wait_events(1, 20, ok2);
      checks++;
      if (!ok || !ok2 || !is_err) begin
        fails++;
        $display("FAIL reject%0d_timeout: handshake %0d event %0d model_err %0d want 1 1 1", i, ok, ok2, is_err);
      end
      checks++;
      if (err_obs.size() != 1 || err_obs[0] != t_evt || done_obs.size() != 0 || obs_wr.size() != 0) begin
        fails++;
        $display("FAIL reject%0d_err: errs %0d (first %0d) dones %0d writes %0d want 1 at %0d, 0, 0", i,
                 err_obs.size(), (err_obs.size() > 0) ? err_obs[0] : -1, done_obs.size(), obs_wr.size(), t + 1);
      end
      checks++;
      if (a_ready !== 1'b1 || a_busy !== 1'b0) begin
        fails++;
        $display("FAIL reject%0d_ready: ready %b busy %b want 1 0", i, a_ready, a_busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    int t1, t2, e1, e2; bit ok1, ok2, ok3, er; logic [W-1:0] e, o;
    clear_logs();
    send_cmd(2'b10, 8'd0, 8'h00, t1, ok1);
    build_exp(2, 0, 8'h00, t1, GAP_A, e1, er);
    send_cmd(2'b00, 8'd7, 8'h85, t2, ok2);
    build_exp(0, 7, 8'h85, t2, GAP_A, e2, er);
    checks++;
    if (!ok1 || !ok2 || t2 != t1 + 47) begin
      fails++;
      $display("FAIL b2b_accept: second taken at %0d want %0d", t2, t1 + 47);
    end
    wait_events(2, 100, ok3);
    checks++;
    if (!ok3) begin
      fails++;
      $display("FAIL b2b_timeout: got %0d events want 2", done_obs.size() + err_obs.size());
    end
    checks++;
    if (obs_wr.size() != exp_q.size()) begin
      fails++;
      $display("FAIL b2b_count: got %0d writes want %0d", obs_wr.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_wr.size() > 0) begin
      e = exp_q.pop_front(); o = obs_wr.pop_front();
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL b2b_write: got %h want %h", o, e);
      end
    end
    checks++;
    if (done_obs.size() != 2 || done_obs[0] != e1 || done_obs[1] != e2) begin
      fails++;
      $display("FAIL b2b_done: got %0d dones want 2 at %0d and %0d", done_obs.size(), e1, e2);
    end
  endtask

  task automatic test_reset_mid_bulk();
    int t; bit ok; logic [W-1:0] e, o;
    clear_logs();
    send_cmd(2'b10, 8'd0, 8'h00, t, ok);
    for (int k = 0; k < 4; k++)
      exp_q.push_back({16'(t + 1 + k * (1 + GAP_A)), 8'(k), 32'(model_entry(2, k, 8'h00))});
    repeat (9) @(negedge clk);   // cycle t+10
    rst = 1'b1;
    @(negedge clk);              // cycle t+11
    rst = 1'b0;
    checks++;
    if (a_ready !== 1'b0 || a_busy !== 1'b0) begin
      fails++;
      $display("FAIL midrst_hold: ready %b busy %b want 0 0", a_ready, a_busy);
    end
    @(negedge clk);              // cycle t+12
    checks++;
    if (!ok || a_ready !== 1'b1 || a_busy !== 1'b0) begin
      fails++;
      $display("FAIL midrst_ready: ready %b busy %b want 1 0", a_ready, a_busy);
    end
    repeat (60) @(negedge clk);
    checks++;
    if (obs_wr.size() != exp_q.size() || done_obs.size() != 0) begin
      fails++;
      $display("FAIL midrst_count: got %0d writes %0d dones want %0d, 0", obs_wr.size(), done_obs.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_wr.size() > 0) begin
      e = exp_q.pop_front(); o = obs_wr.pop_front();
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL midrst_write: got %h want %h", o, e);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      int t, t_evt, opi; bit ok, ok2, is_err; logic [7:0] d, a; logic [W-1:0] e, o;
      clear_logs();
      opi = $urandom_range(0, 5);
      if (opi > 3) opi = 0;
      a = 8'($urandom_range(0, 18));
      d = 8'($urandom);
      if ($urandom_range(0, 2) != 0) d[6:4] = 3'b000;
      send_cmd(2'(opi), a, d, t, ok);
      build_exp(opi, int'(a), d, t, GAP_A, t_evt, is_err);
      wait_events(1, 100, ok2);
      checks++;
      if (!ok || !ok2) begin
        fails++;
        $display("FAIL rand%0d_timeout: handshake %0d event %0d want 1 1", i, ok, ok2);
      end
      checks++;
      if (obs_wr.size() != exp_q.size()) begin
        fails++;
        $display("FAIL rand%0d_count: op %0d addr %0d data %h got %0d writes want %0d", i, opi, a, d,
                 obs_wr.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_wr.size() > 0) begin
        e = exp_q.pop_front(); o = obs_wr.pop_front();
        checks++;
        if (o !== e) begin
          fails++;
          $display("FAIL rand%0d_write: got %h want %h", i, o, e);
        end
      end
      checks++;
      if (is_err ? (err_obs.size() != 1 || err_obs[0] != t_evt || done_obs.size() != 0)
                 : (done_obs.size() != 1 || done_obs[0] != t_evt || err_obs.size() != 0)) begin
        fails++;
        $display("FAIL rand%0d_event: dones %0d errs %0d want %s at %0d", i, done_obs.size(), err_obs.size(),
                 is_err ? "err" : "done", t_evt);
      end
      checks++;
      if (a_ready !== 1'b1) begin
        fails++;
        $display("FAIL rand%0d_ready: got %b want 1", i, a_ready);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    @(negedge clk);
    test_reset();
    test_single_write();
    test_load_default();
    test_clear_gap0();
    test_rejects();
    test_back_to_back();
    test_reset_mid_bulk();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
